// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word-organised synchronous RAM with byte-lane writes and write-first read data.
// Adds sticky out-of-range detection and saturating read/write access counters.
module data_sram_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h1C00_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_sram_en,
    input  logic [3:0]       data_sram_we,
    input  logic [31:0]      data_sram_addr,
    input  logic [31:0]      data_sram_wdata,
    output logic [31:0]      data_sram_rdata,
    output logic             oob_err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  in_range;
    logic                  is_write;
    logic [31:0]           cur_word;
    logic [31:0]           merged_word;
    logic                  unused_addr_bits;

    assign word_idx         = data_sram_addr[DEPTH_LOG2+1:2];
    assign in_range         = (data_sram_addr[31:DEPTH_LOG2+2] == ADDR_BASE[31:DEPTH_LOG2+2]);
    assign is_write         = |data_sram_we;
    assign cur_word         = mem[word_idx];
    assign unused_addr_bits = ^data_sram_addr[1:0];

    // Write-first: the returned word is the stored word with this cycle's enabled lanes overlaid.
    always_comb begin
        merged_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (data_sram_we[i]) begin
                merged_word[8*i +: 8] = data_sram_wdata[8*i +: 8];
            end
        end
    end

    // The array is deliberately left out of reset so it maps onto block RAM with byte enables.
    always_ff @(posedge clk) begin
        if (!reset && data_sram_en && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_sram_rdata <= 32'h0;
            oob_err         <= 1'b0;
            rd_cnt          <= '0;
            wr_cnt          <= '0;
        end else if (data_sram_en) begin
            if (in_range) begin
                data_sram_rdata <= merged_word;
            end else begin
                data_sram_rdata <= 32'h0;
                oob_err         <= 1'b1;
            end
            // Counters saturate at all-ones and count out-of-range accesses too.
            if (is_write) begin
                if (wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
            end else begin
                if (rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
            end
        end
    end

endmodule
